// File: rtl/output_classifier.sv
// Output layer: snapshots layer 2 activations, runs N_OUT bias+MAC neurons from a serial
// bias/weight stream, and tracks a running argmax over the saturated int8 scores.
module output_classifier #(
   parameter int unsigned N_IN  = 32,
   parameter int unsigned N_OUT = 10,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned SHIFT = 7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [8*N_IN-1:0]          reg_layer2,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [8*N_OUT-1:0]         scores,
   output logic [$clog2(N_OUT)-1:0]   class_idx,
   output logic [7:0]                 class_score,
   output logic                       busy,
   output logic                       done,
   output logic                       result_valid
);

   localparam int unsigned IDX_W = $clog2(N_OUT);
   localparam int unsigned I_W   = $clog2(N_IN);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BIAS  = 2'd1;
   localparam logic [1:0] ST_MAC   = 2'd2;
   localparam logic [1:0] ST_STORE = 2'd3;

   localparam logic [I_W-1:0]   LAST_I = I_W'(N_IN - 1);
   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_OUT - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);
   // One below the smallest int8, so neuron 0 always takes the lead.
   localparam logic signed [8:0] BEST_INIT = -9'sd129;

   logic [1:0]               state_q, state_d;
   logic [8*N_IN-1:0]        x_q, x_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [I_W-1:0]           i_q, i_d;
   logic [IDX_W-1:0]         k_q, k_d;
   logic [8*N_OUT-1:0]       scores_q, scores_d;
   logic [IDX_W-1:0]         class_idx_q, class_idx_d;
   logic [7:0]               class_score_q, class_score_d;
   logic signed [8:0]        best_q, best_d;
   logic                     done_q, done_d;
   logic                     result_valid_q, result_valid_d;

   logic signed [7:0]        x_sel;
   logic signed [7:0]        w_in;
   logic signed [15:0]       prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_shr;
   logic signed [7:0]        sat;
   logic signed [8:0]        sat_ext;

   // Datapath: product of the current activation and weight beat, plus the store-time
   // floor shift and int8 clamp.
   always_comb begin
      x_sel    = x_q[8*i_q +: 8];
      w_in     = in_data;
      prod     = x_sel * w_in;
      prod_ext = {{(ACC_W-16){prod[15]}}, prod};
      bias_ext = {{(ACC_W-8){in_data[7]}}, in_data};
      acc_shr  = acc_q >>> SHIFT;
      if (acc_shr > SAT_MAX) begin
         sat = 8'sd127;
      end else if (acc_shr < SAT_MIN) begin
         sat = -8'sd128;
      end else begin
         sat = acc_shr[7:0];
      end
      sat_ext = {sat[7], sat};
   end

   always_comb begin
      state_d        = state_q;
      x_d            = x_q;
      acc_d          = acc_q;
      i_d            = i_q;
      k_d            = k_q;
      scores_d       = scores_q;
      class_idx_d    = class_idx_q;
      class_score_d  = class_score_q;
      best_d         = best_q;
      done_d         = 1'b0;
      result_valid_d = result_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d            = reg_layer2;
               k_d            = '0;
               i_d            = '0;
               result_valid_d = 1'b0;
               best_d         = BEST_INIT;
               state_d        = ST_BIAS;
            end
         end
         ST_BIAS: begin
            if (in_valid) begin
               acc_d   = bias_ext;
               i_d     = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            if (in_valid) begin
               acc_d = acc_q + prod_ext;
               i_d   = i_q + I_W'(1);
               if (i_q == LAST_I) begin
                  state_d = ST_STORE;
               end
            end
         end
         ST_STORE: begin
            scores_d[8*k_q +: 8] = sat;
            // Strict compare keeps the lower index on ties.
            if (sat_ext > best_q) begin
               best_d        = sat_ext;
               class_idx_d   = k_q;
               class_score_d = sat;
            end
            if (k_q == LAST_K) begin
               done_d         = 1'b1;
               result_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               k_d     = k_q + IDX_W'(1);
               state_d = ST_BIAS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         x_q            <= '0;
         acc_q          <= '0;
         i_q            <= '0;
         k_q            <= '0;
         scores_q       <= '0;
         class_idx_q    <= '0;
         class_score_q  <= '0;
         best_q         <= BEST_INIT;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         x_q            <= x_d;
         acc_q          <= acc_d;
         i_q            <= i_d;
         k_q            <= k_d;
         scores_q       <= scores_d;
         class_idx_q    <= class_idx_d;
         class_score_q  <= class_score_d;
         best_q         <= best_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign in_ready     = (state_q == ST_BIAS) || (state_q == ST_MAC);
   assign busy         = (state_q != ST_IDLE);
   assign scores       = scores_q;
   assign class_idx    = class_idx_q;
   assign class_score  = class_score_q;
   assign done         = done_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_output_classifier.sv
// Bench for output_classifier: directed and random runs checked against an arithmetic
// model of the bias + dot-product, floor-shift, clamp and argmax rules.
module tb_output_classifier;

   localparam int N_IN      = 32;
   localparam int N_OUT     = 10;
   localparam int BEATS     = N_OUT * (N_IN + 1);
   localparam int RUN_EDGES = N_OUT * (N_IN + 2);

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [8*N_IN-1:0]   reg_layer2 = '0;
   logic [7:0]          in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [8*N_OUT-1:0]  scores;
   logic [3:0]          class_idx;
   logic [7:0]          class_score;
   logic                busy;
   logic                done;
   logic                result_valid;

   output_classifier dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .reg_layer2   (reg_layer2),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .scores       (scores),
      .class_idx    (class_idx),
      .class_score  (class_score),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int xv [N_IN];
   int bv [N_OUT];
   int wv [N_OUT][N_IN];

   logic [8*N_OUT-1:0] exp_scores;
   int                 exp_idx;
   int                 exp_score;

   // Reference: integer dot product, floor divide by 128, clamp, strict-greater argmax.
   function automatic void compute_model();
      int best;
      best = -129;
      exp_idx = 0;
      exp_score = 0;
      for (int k = 0; k < N_OUT; k++) begin
         int acc;
         int s;
         acc = bv[k];
         for (int i = 0; i < N_IN; i++) acc += xv[i] * wv[k][i];
         s = acc >>> 7;
         if (s > 127) s = 127;
         if (s < -128) s = -128;
         exp_scores[8*k +: 8] = 8'(s);
         if (s > best) begin
            best = s;
            exp_idx = k;
            exp_score = s;
         end
      end
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic fill_const(input int x, input int b, input int w);
      for (int i = 0; i < N_IN; i++) xv[i] = x;
      for (int k = 0; k < N_OUT; k++) begin
         bv[k] = b;
         for (int i = 0; i < N_IN; i++) wv[k][i] = w;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N_IN; i++) xv[i] = rnd8();
      for (int k = 0; k < N_OUT; k++) begin
         bv[k] = rnd8();
         for (int i = 0; i < N_IN; i++) wv[k][i] = int'($urandom_range(15)) - 8;
      end
   endtask

   // Caller must be at a negedge; start is raised immediately so a call made in the done
   // cycle exercises back-to-back acceptance. Returns at the negedge where done is seen.
   task automatic run_stream(input int gap_pct, input bit scramble, input int start_pulse_edge,
                             input int abort_beat, output int done_edge, output int ready_bad);
      int   stream [BEATS];
      int   idx;
      int   e;
      int   n;
      logic exp_ready;
      n = 0;
      for (int k = 0; k < N_OUT; k++) begin
         stream[n++] = bv[k];
         for (int i = 0; i < N_IN; i++) stream[n++] = wv[k][i];
      end
      for (int i = 0; i < N_IN; i++) reg_layer2[8*i +: 8] = 8'(xv[i]);
      start     = 1'b1;
      in_valid  = 1'b0;
      done_edge = -1;
      ready_bad = 0;
      idx       = 0;
      @(posedge clk);
      e = 0;
      while (e < 4000) begin
         @(negedge clk);
         start = 1'b0;
         if (scramble) reg_layer2 = {8{$urandom()}};
         if (start_pulse_edge == e) begin
            start = 1'b1;
            reg_layer2 = {8{$urandom()}};
         end
         exp_ready = (e < RUN_EDGES) && ((e % (N_IN + 2)) != N_IN + 1);
         if (gap_pct == 0 && in_ready !== exp_ready) ready_bad++;
         if (done === 1'b1) begin
            done_edge = e;
            break;
         end
         if (abort_beat >= 0 && idx == abort_beat) begin
            in_valid = 1'b0;
            rst_n = 1'b0;
            break;
         end
         if (idx < BEATS && int'($urandom_range(99)) >= gap_pct) begin
            in_valid = 1'b1;
            in_data  = 8'(stream[idx]);
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         e++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({scores, class_idx, class_score, done, busy, result_valid, in_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {scores, class_idx, class_score, done, busy, result_valid, in_ready});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, in_ready, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset: got busy/ready/done=%b expected 000",
                  {busy, in_ready, done});
      end
   endtask

   task automatic test_uniform();
      int de;
      int rb;
      fill_const(16, 0, 16);
      @(negedge clk);
      run_stream(0, 1'b0, -1, -1, de, rb);
      checks++;
      if (de !== RUN_EDGES) begin
         errors++;
         $display("FAIL uniform_done_edge: got %0d expected %0d", de, RUN_EDGES);
      end
      checks++;
      if (rb !== 0) begin
         errors++;
         $display("FAIL uniform_in_ready_pattern: got %0d bad cycles expected 0", rb);
      end
      checks++;
      if (scores !== {N_OUT{8'h40}}) begin
         errors++;
         $display("FAIL uniform_scores: got %h expected %h", scores, {N_OUT{8'h40}});
      end
      checks++;
      if (class_idx !== 4'd0 || class_score !== 8'd64) begin
         errors++;
         $display("FAIL uniform_argmax: got idx=%0d score=%0d expected idx=0 score=64",
                  class_idx, class_score);
      end
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL uniform_status: got rv=%b busy=%b expected rv=1 busy=0",
                  result_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result_valid !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse_width: got done=%b rv=%b expected done=0 rv=1",
                  done, result_valid);
      end
   endtask

   task automatic test_onehot();
      int de;
      int rb;
      fill_const(16, 0, 0);
      for (int i = 0; i < N_IN; i++) wv[7][i] = 16;
      @(negedge clk);
      run_stream(0, 1'b0, -1, -1, de, rb);
      checks++;
      if (scores !== {16'h0000, 8'h40, {7{8'h00}}}) begin
         errors++;
         $display("FAIL onehot_scores: got %h expected %h", scores,
                  {16'h0000, 8'h40, {7{8'h00}}});
      end
      checks++;
      if (class_idx !== 4'd7 || class_score !== 8'd64) begin
         errors++;
         $display("FAIL onehot_argmax: got idx=%0d score=%0d expected idx=7 score=64",
                  class_idx, class_score);
      end
   endtask

   task automatic test_saturation();
      int de;
      int rb;
      fill_const(127, 0, 0);
      for (int i = 0; i < N_IN; i++) begin
         wv[0][i] = 127;
         wv[1][i] = -128;
      end
      bv[2] = -1;
      @(negedge clk);
      run_stream(0, 1'b0, -1, -1, de, rb);
      checks++;
      if (scores[7:0] !== 8'h7f) begin
         errors++;
         $display("FAIL sat_positive: got %h expected 7f", scores[7:0]);
      end
      checks++;
      if (scores[15:8] !== 8'h80) begin
         errors++;
         $display("FAIL sat_negative: got %h expected 80", scores[15:8]);
      end
      checks++;
      if (scores[23:16] !== 8'hff) begin
         errors++;
         $display("FAIL floor_shift: got %h expected ff", scores[23:16]);
      end
      checks++;
      if (class_idx !== 4'd0 || class_score !== 8'h7f) begin
         errors++;
         $display("FAIL sat_argmax: got idx=%0d score=%h expected idx=0 score=7f",
                  class_idx, class_score);
      end
   endtask

   task automatic test_gaps();
      int                 de;
      int                 rb;
      logic [8*N_OUT-1:0] ref_scores;
      logic [3:0]         ref_idx;
      for (int trial = 0; trial < 3; trial++) begin
         fill_random();
         compute_model();
         @(negedge clk);
         run_stream(0, 1'b0, -1, -1, de, rb);
         ref_scores = scores;
         ref_idx    = class_idx;
         checks++;
         if (scores !== exp_scores || class_idx !== 4'(exp_idx) ||
             class_score !== 8'(exp_score)) begin
            errors++;
            $display("FAIL random_nogap[%0d]: got %h/%0d/%0d expected %h/%0d/%0d", trial,
                     scores, class_idx, $signed(class_score), exp_scores, exp_idx, exp_score);
         end
         @(negedge clk);
         run_stream(30, 1'b1, -1, -1, de, rb);
         checks++;
         if (de < RUN_EDGES) begin
            errors++;
            $display("FAIL gap_done_seen[%0d]: got edge %0d expected >= %0d", trial, de,
                     RUN_EDGES);
         end
         checks++;
         if (scores !== ref_scores || class_idx !== ref_idx) begin
            errors++;
            $display("FAIL gap_vs_nogap[%0d]: got %h/%0d expected %h/%0d", trial, scores,
                     class_idx, ref_scores, ref_idx);
         end
         checks++;
         if (scores !== exp_scores || class_score !== 8'(exp_score)) begin
            errors++;
            $display("FAIL gap_vs_model[%0d]: got %h/%0d expected %h/%0d", trial, scores,
                     $signed(class_score), exp_scores, exp_score);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_idle[%0d]: got %b expected 0", trial, in_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      int de;
      int rb;
      fill_random();
      compute_model();
      @(negedge clk);
      run_stream(0, 1'b0, 100, -1, de, rb);
      checks++;
      if (de !== RUN_EDGES || scores !== exp_scores || class_idx !== 4'(exp_idx)) begin
         errors++;
         $display("FAIL midrun_start_ignored: got edge=%0d %h/%0d expected edge=%0d %h/%0d",
                  de, scores, class_idx, RUN_EDGES, exp_scores, exp_idx);
      end
      fill_random();
      compute_model();
      run_stream(0, 1'b0, -1, -1, de, rb);
      checks++;
      if (de !== RUN_EDGES) begin
         errors++;
         $display("FAIL back_to_back_done_edge: got %0d expected %0d", de, RUN_EDGES);
      end
      checks++;
      if (scores !== exp_scores || class_idx !== 4'(exp_idx) ||
          class_score !== 8'(exp_score)) begin
         errors++;
         $display("FAIL back_to_back_result: got %h/%0d/%0d expected %h/%0d/%0d", scores,
                  class_idx, $signed(class_score), exp_scores, exp_idx, exp_score);
      end
   endtask

   task automatic test_mid_reset();
      int de;
      int rb;
      fill_random();
      @(negedge clk);
      run_stream(0, 1'b0, -1, 150, de, rb);
      #1;
      checks++;
      if ({scores, class_idx, class_score, done, busy, result_valid, in_ready} !== '0) begin
         errors++;
         $display("FAIL midrun_reset_outputs: got %h expected 0",
                  {scores, class_idx, class_score, done, busy, result_valid, in_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_random();
      compute_model();
      run_stream(0, 1'b0, -1, -1, de, rb);
      checks++;
      if (de !== RUN_EDGES || scores !== exp_scores || class_idx !== 4'(exp_idx) ||
          class_score !== 8'(exp_score)) begin
         errors++;
         $display("FAIL after_reset_run: got edge=%0d %h/%0d/%0d expected edge=%0d %h/%0d/%0d",
                  de, scores, class_idx, $signed(class_score), RUN_EDGES, exp_scores, exp_idx,
                  exp_score);
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_onehot();
      test_saturation();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
